// File: rtl/logic_pkg.sv
// Shared definitions for the sequential logic unit: op encodings, FSM states
// and a helper for sizing the slice counter.
package logic_pkg;

    typedef enum logic [1:0] {
        LOGIC_AND  = 2'b00,
        LOGIC_OR   = 2'b01,
        LOGIC_XOR  = 2'b10,
        LOGIC_ANDN = 2'b11
    } logic_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    // Slice counter width: enough bits to count NSLICE slices, never zero.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/seq_logic_unit_if.sv
// Operand/result handshake bundle for seq_logic_unit.
// out_zero exists only when SEQ_LOGIC_ZERO_FLAG_EN is defined.
interface seq_logic_unit_if
    import logic_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic_op_t        in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
    logic             out_zero;
`endif

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
        input  out_zero,
`endif
        input  in_ready, out_valid, out_result
    );

    // The logic unit itself.
    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
        output out_zero,
`endif
        output in_ready, out_valid, out_result
    );

endinterface

// File: rtl/seq_logic_slice.sv
// Combinational SLICE-bit evaluator for AND/OR/XOR/ANDN.
module seq_logic_slice
    import logic_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic_op_t        op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y
);

    // Select the bitwise function for this slice.
    always_comb begin
        y = '0;
        case (op)
            LOGIC_AND:  y = a & b;
            LOGIC_OR:   y = a | b;
            LOGIC_XOR:  y = a ^ b;
            LOGIC_ANDN: y = a & ~b;
            default:    y = '0;
        endcase
    end

endmodule

// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: evaluates SLICE bits per cycle over WIDTH-bit
// latched operands, valid/ready on both sides.
// Optional zero flag enabled by defining SEQ_LOGIC_ZERO_FLAG_EN.
module seq_logic_unit
    import logic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input logic            clk,
    input logic            rst,
    seq_logic_unit_if.slave bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = idx_width(NSLICE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_slice
        $error("seq_logic_unit: WIDTH must be a multiple of SLICE");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic_op_t        op_q;
    logic [IDXW-1:0]  idx_q;
    logic [SLICE-1:0] slice_a, slice_b, slice_y;
    logic             accept;
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
    logic             zero_q;
`endif

    // Route the current slice of the latched operands to the evaluator.
    always_comb begin
        slice_a = a_q[int'(idx_q) * SLICE +: SLICE];
        slice_b = b_q[int'(idx_q) * SLICE +: SLICE];
    end

    seq_logic_slice #(.SLICE(SLICE)) u_slice (
        .op (op_q),
        .a  (slice_a),
        .b  (slice_b),
        .y  (slice_y)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                if (bus.in_valid) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (idx_q == LAST_IDX) state_d = ST_DONE;
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, slice counter and result assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= LOGIC_AND;
            idx_q    <= '0;
            result_q <= '0;
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
        end else if (accept) begin
            a_q      <= bus.in_a;
            b_q      <= bus.in_b;
            op_q     <= bus.in_op;
            idx_q    <= '0;
            result_q <= '0;
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
            zero_q   <= 1'b1;
`endif
        end else if (state_q == ST_BUSY) begin
            result_q[int'(idx_q) * SLICE +: SLICE] <= slice_y;
            idx_q <= idx_q + 1'b1;
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
            zero_q <= zero_q & ~(|slice_y);
`endif
        end
    end

    assign bus.out_result = result_q;
`ifdef SEQ_LOGIC_ZERO_FLAG_EN
    assign bus.out_zero = (state_q == ST_DONE) & zero_q;
`endif

endmodule
